// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit of the 16-bit rudimentary machine:
// state codes, opcode classes, ALU functions, branch condition codes and
// register-file read-select codes.
package control_unit_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StAlu    = 3'd3,
    StLoad   = 3'd4,
    StStore  = 3'd5,
    StBranch = 3'd6,
    StHalt   = 3'd7
  } state_e;

  // Opcode classes, IR[15:14]
  localparam logic [1:0] OpcLoad   = 2'b00;
  localparam logic [1:0] OpcStore  = 2'b01;
  localparam logic [1:0] OpcBranch = 2'b10;
  localparam logic [1:0] OpcAlu    = 2'b11;

  // ALU functions, IR[2:0]
  localparam logic [2:0] FnAddi = 3'b000;
  localparam logic [2:0] FnSubi = 3'b001;
  localparam logic [2:0] FnIll0 = 3'b010;
  localparam logic [2:0] FnIll1 = 3'b011;
  localparam logic [2:0] FnAdd  = 3'b100;
  localparam logic [2:0] FnSub  = 3'b101;
  localparam logic [2:0] FnAsr  = 3'b110;
  localparam logic [2:0] FnAnd  = 3'b111;

  // Branch conditions, IR[13:11]
  localparam logic [2:0] CondAlways = 3'b000;
  localparam logic [2:0] CondZ      = 3'b001;
  localparam logic [2:0] CondN      = 3'b010;
  localparam logic [2:0] CondNz     = 3'b011;
  localparam logic [2:0] CondNever  = 3'b100;
  localparam logic [2:0] CondNotZ   = 3'b101;
  localparam logic [2:0] CondNotN   = 3'b110;
  localparam logic [2:0] CondPos    = 3'b111;

  // Register-file read select: Rd = IR[13:11], Ri = IR[10:8], Rf2 = IR[7:5]
  localparam logic [1:0] SelRd  = 2'b00;
  localparam logic [1:0] SelRi  = 2'b01;
  localparam logic [1:0] SelRf2 = 2'b10;

  function automatic logic is_illegal_func(input logic [2:0] fn);
    return (fn == FnIll0) || (fn == FnIll1);
  endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
// Branch condition evaluator (purely combinational).
// Ports:
//   cond_i    branch condition code, IR[13:11]
//   flag_z_i  zero flag
//   flag_n_i  negative flag
//   taken_o   1 = branch is taken
module control_unit_branch_cond
  import control_unit_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       flag_z_i,
  input  logic       flag_n_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      CondAlways: taken_o = 1'b1;
      CondZ:      taken_o = flag_z_i;
      CondN:      taken_o = flag_n_i;
      CondNz:     taken_o = flag_n_i | flag_z_i;
      CondNever:  taken_o = 1'b0;
      CondNotZ:   taken_o = ~flag_z_i;
      CondNotN:   taken_o = ~flag_n_i;
      CondPos:    taken_o = ~flag_n_i & ~flag_z_i;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit rudimentary machine.
// Drives the register-file read select, write enable, IR/PC/RA/A latch loads,
// ALU function and the memory request/acknowledge handshake.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   run                 execute enable, sampled in IDLE and at instruction end
//   ir, flag_z, flag_n  instruction register and condition flags
//   mem_ack             memory completes the current request this cycle
//   mem_req/mem_we/sel_addr          memory request, write, address select (0 PC, 1 RA)
//   ld_ir/ld_pc/sel_pc/ld_ra/ld_a    datapath latch controls
//   sel_Rf/Erd/sel_regin/sel_imm     register file and ALU operand controls
//   alu_op/ld_flags                  ALU function and flag update
//   illegal             sticky illegal-instruction indicator
//   state_o             current state (debug)
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [IW-1:0]  ir,
  input  logic           flag_z,
  input  logic           flag_n,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic           sel_addr,
  output logic           ld_ir,
  output logic           ld_pc,
  output logic           sel_pc,
  output logic           ld_ra,
  output logic           ld_a,
  output logic [1:0]     sel_Rf,
  output logic           Erd,
  output logic           sel_regin,
  output logic           sel_imm,
  output logic [OPW-1:0] alu_op,
  output logic           ld_flags,
  output logic           illegal,
  output logic [2:0]     state_o
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   taken;
  state_e end_state;

  // IR[10:3] feed the datapath directly; the sequencer never looks at them.
  logic unused_ir;
  assign unused_ir = ^ir[10:3];

  control_unit_branch_cond u_branch_cond (
    .cond_i   (ir[13:11]),
    .flag_z_i (flag_z),
    .flag_n_i (flag_n),
    .taken_o  (taken)
  );

  // Instruction boundary: run decides whether to fetch again or park.
  assign end_state = run ? StFetch : StIdle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    sel_addr  = 1'b0;
    ld_ir     = 1'b0;
    ld_pc     = 1'b0;
    sel_pc    = 1'b0;
    ld_ra     = 1'b0;
    ld_a      = 1'b0;
    sel_Rf    = SelRd;
    Erd       = 1'b0;
    sel_regin = 1'b0;
    sel_imm   = 1'b0;
    alu_op    = '0;
    ld_flags  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        // PC+1 is taken in the same cycle the instruction word arrives.
        if (mem_ack) begin
          ld_ir   = 1'b1;
          ld_pc   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Read Ri once: it feeds both the RA address adder and operand A.
        sel_Rf = SelRi;
        ld_ra  = 1'b1;
        ld_a   = 1'b1;
        unique case (ir[15:14])
          OpcLoad:   state_d = StLoad;
          OpcStore:  state_d = StStore;
          OpcBranch: state_d = StBranch;
          OpcAlu: begin
            if (is_illegal_func(ir[2:0])) begin
              state_d   = StHalt;
              illegal_d = 1'b1;
            end else begin
              state_d = StAlu;
            end
          end
        endcase
      end
      StAlu: begin
        alu_op    = ir[OPW-1:0];
        Erd       = 1'b1;
        sel_regin = 1'b1;
        ld_flags  = 1'b1;
        if (ir[2]) begin
          sel_Rf = SelRf2;
        end else begin
          sel_Rf  = SelRd;
          sel_imm = 1'b1;
        end
        state_d = end_state;
      end
      StLoad: begin
        mem_req  = 1'b1;
        sel_addr = 1'b1;
        if (mem_ack) begin
          Erd      = 1'b1;
          ld_flags = 1'b1;
          state_d  = end_state;
        end
      end
      StStore: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        sel_addr = 1'b1;
        sel_Rf   = SelRd;
        if (mem_ack) state_d = end_state;
      end
      StBranch: begin
        ld_pc   = taken;
        sel_pc  = taken;
        state_d = end_state;
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized
// instruction streams checked cycle by cycle against a behavioural model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] ir;
  logic        flag_z, flag_n, mem_ack;
  logic        mem_req, mem_we, sel_addr, ld_ir, ld_pc, sel_pc, ld_ra, ld_a;
  logic [1:0]  sel_Rf;
  logic        Erd, sel_regin, sel_imm;
  logic [2:0]  alu_op;
  logic        ld_flags, illegal;
  logic [2:0]  unused_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_unit #(.IW(16), .OPW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .ir        (ir),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .sel_addr  (sel_addr),
    .ld_ir     (ld_ir),
    .ld_pc     (ld_pc),
    .sel_pc    (sel_pc),
    .ld_ra     (ld_ra),
    .ld_a      (ld_a),
    .sel_Rf    (sel_Rf),
    .Erd       (Erd),
    .sel_regin (sel_regin),
    .sel_imm   (sel_imm),
    .alu_op    (alu_op),
    .ld_flags  (ld_flags),
    .illegal   (illegal),
    .state_o   (unused_state)
  );

  typedef struct packed {
    logic       mem_req, mem_we, sel_addr, ld_ir, ld_pc, sel_pc, ld_ra, ld_a;
    logic [1:0] sel_rf;
    logic       erd, sel_regin, sel_imm;
    logic [2:0] alu_op;
    logic       ld_flags, illegal;
  } outs_t;

  function automatic outs_t observe();
    outs_t o;
    o.mem_req   = mem_req;   o.mem_we    = mem_we;    o.sel_addr = sel_addr;
    o.ld_ir     = ld_ir;     o.ld_pc     = ld_pc;     o.sel_pc   = sel_pc;
    o.ld_ra     = ld_ra;     o.ld_a      = ld_a;      o.sel_rf   = sel_Rf;
    o.erd       = Erd;       o.sel_regin = sel_regin; o.sel_imm  = sel_imm;
    o.alu_op    = alu_op;    o.ld_flags  = ld_flags;  o.illegal  = illegal;
    return o;
  endfunction

  // Branch rule: low two bits pick always/Z/N/N|Z, bit 2 inverts the sense.
  function automatic bit ref_taken(input logic [2:0] c, input bit z, input bit n);
    bit base;
    case (c[1:0])
      2'd0:    base = 1'b1;
      2'd1:    base = z;
      2'd2:    base = n;
      default: base = n | z;
    endcase
    return c[2] ? !base : base;
  endfunction

  task automatic check_outs(input string tag, input outs_t e);
    outs_t o;
    o = observe();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Inputs are already set: settle, compare, then advance one clock.
  task automatic cycle(input string tag, input outs_t e);
    #1;
    check_outs(tag, e);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in the fetch state.
  task automatic exec(input logic [15:0] instr, input int fwait, input int mwait,
                      input bit run_after, input bit z, input bit n, output bit halted);
    outs_t e;
    bit    is_store;
    bit    t;
    ir = instr; flag_z = z; flag_n = n; halted = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < fwait; i++) begin
      run = 1'($urandom_range(0, 1));
      e = '0; e.mem_req = 1'b1;
      cycle("fetch_wait", e);
    end
    mem_ack = 1'b1; run = 1'($urandom_range(0, 1));
    e = '0; e.mem_req = 1'b1; e.ld_ir = 1'b1; e.ld_pc = 1'b1;
    cycle("fetch_ack", e);
    mem_ack = 1'b0; run = 1'($urandom_range(0, 1));
    e = '0; e.sel_rf = 2'b01; e.ld_ra = 1'b1; e.ld_a = 1'b1;
    cycle("decode", e);
    case (instr[15:14])
      2'b11: begin
        if (instr[2:1] == 2'b01) begin
          halted = 1'b1; run = 1'b1; mem_ack = 1'b1;
          e = '0; e.illegal = 1'b1;
          for (int i = 0; i < 4; i++) cycle("halt", e);
          mem_ack = 1'b0;
        end else begin
          run = run_after;
          e = '0; e.alu_op = instr[2:0]; e.erd = 1'b1; e.sel_regin = 1'b1;
          e.ld_flags = 1'b1; e.sel_imm = !instr[2];
          e.sel_rf = instr[2] ? 2'b10 : 2'b00;
          cycle("alu", e);
        end
      end
      2'b10: begin
        run = run_after;
        t = ref_taken(instr[13:11], z, n);
        e = '0; e.ld_pc = t; e.sel_pc = t;
        cycle("branch", e);
      end
      default: begin
        is_store = instr[14];
        for (int i = 0; i < mwait; i++) begin
          run = 1'($urandom_range(0, 1));
          e = '0; e.mem_req = 1'b1; e.sel_addr = 1'b1; e.mem_we = is_store;
          cycle(is_store ? "store_wait" : "load_wait", e);
        end
        mem_ack = 1'b1; run = run_after;
        e = '0; e.mem_req = 1'b1; e.sel_addr = 1'b1; e.mem_we = is_store;
        e.erd = !is_store; e.ld_flags = !is_store;
        cycle(is_store ? "store_ack" : "load_ack", e);
        mem_ack = 1'b0;
      end
    endcase
    if (!halted && !run_after) begin
      run = 1'b0;
      cycle("idle_after", '0);
      run = 1'b1;
      cycle("idle_restart", '0);
    end
  endtask

  initial begin
    outs_t e;
    bit    h;
    logic [15:0] instr;
    rst_n = 1'b0; run = 1'b0; ir = '0; flag_z = 1'b0; flag_n = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    check_outs("reset", '0);
    rst_n = 1'b1;

    // Reset while a fetch request is outstanding; a late ack must be ignored.
    run = 1'b1;
    cycle("idle_go", '0);
    run = 1'b0;
    e = '0; e.mem_req = 1'b1;
    #1; check_outs("fetch_req", e);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b1;
    cycle("rst_mid_fetch", '0);
    cycle("late_ack", '0);
    mem_ack = 1'b0;
    run = 1'b1;
    cycle("start", '0);

    exec(16'hD944, 0, 0, 1'b1, 1'b0, 1'b0, h);   // ADD R3,R1,R2
    exec(16'hC0F8, 1, 0, 1'b1, 1'b0, 1'b0, h);   // ADDI
    exec(16'h1A05, 0, 3, 1'b1, 1'b0, 1'b0, h);   // LOAD, ack after 3 waits
    exec(16'h4B20, 2, 1, 1'b1, 1'b0, 1'b0, h);   // STORE
    exec(16'h8810, 0, 0, 1'b1, 1'b1, 1'b0, h);   // BEQ, Z=1
    exec(16'h8810, 0, 0, 1'b1, 1'b0, 1'b0, h);   // BEQ, Z=0
    exec(16'hA010, 0, 0, 1'b1, 1'b1, 1'b1, h);   // never-taken
    exec(16'h0123, 0, 2, 1'b0, 1'b0, 1'b0, h);   // LOAD, run dropped mid-way

    for (int k = 0; k < 60; k++) begin
      instr = 16'($urandom);
      if (instr[15:14] == 2'b11 && instr[2:1] == 2'b01) instr[2] = 1'b1;
      exec(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), h);
    end

    exec(16'hC003, 0, 0, 1'b1, 1'b0, 1'b0, h);   // illegal func 011 -> halt
    rst_n = 1'b0; run = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("halt_reset", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
